// File: rtl/totd_occupancy_40mhz_pkg.sv
// Shared types and helpers for the ToT-D occupancy stage.
package totd_occupancy_40mhz_pkg;

  localparam int ADC_WIDTH = 12;

  typedef enum logic [1:0] {
    PH_E0   = 2'd0,
    PH_E1   = 2'd1,
    PH_E2   = 2'd2,
    PH_IDLE = 2'd3
  } phase_e;

  function automatic logic over_thres(input logic [ADC_WIDTH-1:0] adc,
                                      input logic [ADC_WIDTH-1:0] thr);
    return adc > thr;
  endfunction

endpackage

// File: rtl/totd_window_ring.sv
// WINDOW-deep 1-bit circular buffer; each write also returns the bit being displaced.
module totd_window_ring #(
  parameter int WINDOW = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic din,
  output logic dout
);
  localparam int PTR_W = $clog2(WINDOW);

  logic [WINDOW-1:0] ring;
  logic [PTR_W-1:0]  ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ring <= '0;
      ptr  <= '0;
      dout <= 1'b0;
    end else if (wr_en) begin
      dout      <= ring[ptr];
      ring[ptr] <= din;
      ptr       <= (ptr == PTR_W'(WINDOW - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/totd_occupancy_40mhz.sv
// Per-PMT ToT-D occupancy: counts over-threshold 40 MHz samples in a sliding window
// and raises a level trigger when the count meets the occupancy requirement.
module totd_occupancy_40mhz
  import totd_occupancy_40mhz_pkg::*;
#(
  parameter int WINDOW   = 120,
  parameter int OCC_BITS = 7
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [1:0]           ENABLE40,
  input  logic [ADC_WIDTH-1:0] ADC_IN,
  input  logic [ADC_WIDTH-1:0] THRES,
  input  logic [OCC_BITS-1:0]  OCC_THRES,
  output logic [OCC_BITS-1:0]  OCC_COUNT,
  output logic                 TRIG
);
  phase_e phase;
  logic   flag, out_flag;
  logic [OCC_BITS:0] count_next;

  assign phase = phase_e'(ENABLE40);

  totd_window_ring #(.WINDOW(WINDOW)) u_ring (
    .clk   (CLK),
    .reset (RESET),
    .wr_en (phase == PH_E1),
    .din   (flag),
    .dout  (out_flag)
  );

  // One bit of headroom so an underflow shows up as a value above WINDOW.
  assign count_next = {1'b0, OCC_COUNT} + (OCC_BITS+1)'(flag) - (OCC_BITS+1)'(out_flag);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flag      <= 1'b0;
      OCC_COUNT <= '0;
      TRIG      <= 1'b0;
    end else begin
      case (phase)
        PH_E0: begin
          flag <= over_thres(ADC_IN, THRES);
          TRIG <= (OCC_THRES != '0) && (OCC_COUNT >= OCC_THRES);
        end
        PH_E2:   OCC_COUNT <= count_next[OCC_BITS-1:0];
        default: ;
      endcase
    end
  end

  count_in_range: assert property (@(posedge CLK) disable iff (RESET)
    (phase == PH_E2) |-> (count_next <= (OCC_BITS+1)'(WINDOW)));

endmodule

// File: tb/tb_totd_occupancy_40mhz.sv
// Self-checking bench: boundary vector table, directed multi-cycle sequences, random vs. window model.
module tb_totd_occupancy_40mhz;
  localparam int WINDOW = 120;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  ENABLE40 = 2'd0;
  logic [11:0] ADC_IN = '0, THRES = '0;
  logic [6:0]  OCC_THRES = '0;
  logic [6:0]  OCC_COUNT;
  logic        TRIG;

  int checks = 0;
  int errors = 0;
  bit hist[$];  // over-threshold flags of the most recent ticks, oldest first

  always #5 clk = ~clk;

  totd_occupancy_40mhz #(.WINDOW(WINDOW), .OCC_BITS(7)) dut (
    .CLK(clk), .RESET(RESET), .ENABLE40(ENABLE40), .ADC_IN(ADC_IN),
    .THRES(THRES), .OCC_THRES(OCC_THRES), .OCC_COUNT(OCC_COUNT), .TRIG(TRIG)
  );

  function automatic int model_count();
    int s = 0;
    foreach (hist[i]) s += int'(hist[i]);
    return s;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // One 40 MHz tick (E0,E1,E2); checks TRIG after E0 and OCC_COUNT after E2 against the model.
  task automatic tick(input logic [11:0] adc, input logic [11:0] thr, input logic [6:0] ot,
                      output logic got_trig, output logic [6:0] got_cnt);
    int mc;
    mc = model_count();
    @(negedge clk); ENABLE40 = 2'd0; ADC_IN = adc; THRES = thr; OCC_THRES = ot;
    @(posedge clk); #1;
    chk("trig", int'(TRIG), int'(ot != 0 && mc >= int'(ot)));
    got_trig = TRIG;
    @(negedge clk); ENABLE40 = 2'd1;
    @(posedge clk);
    @(negedge clk); ENABLE40 = 2'd2;
    @(posedge clk); #1;
    hist.push_back(adc > thr);
    if (hist.size() > WINDOW) void'(hist.pop_front());
    chk("occ_count", int'(OCC_COUNT), model_count());
    got_cnt = OCC_COUNT;
  endtask

  task automatic do_reset();
    @(negedge clk); RESET = 1'b1; ENABLE40 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", int'(OCC_COUNT), 0);
    chk("reset_trig", int'(TRIG), 0);
    @(negedge clk); RESET = 1'b0;
    hist.delete();
  endtask

  typedef struct {
    logic [11:0] adc;
    logic [11:0] thr;
    logic [6:0]  ot;
    int          exp_cnt;
    int          exp_trig;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic tr;
    logic [6:0] cn;
    int first_trig, trig_ticks, max_cnt, any_trig;

    vt[0] = '{12'd100,  12'd50,   7'd1, 1, 1};
    vt[1] = '{12'd50,   12'd50,   7'd1, 0, 0};
    vt[2] = '{12'd51,   12'd50,   7'd1, 1, 1};
    vt[3] = '{12'd4095, 12'd4095, 7'd1, 0, 0};
    vt[4] = '{12'd0,    12'd0,    7'd1, 0, 0};
    vt[5] = '{12'd1,    12'd0,    7'd0, 1, 0};
    vt[6] = '{12'd4095, 12'd4094, 7'd2, 1, 0};
    vt[7] = '{12'd4095, 12'd0,    7'd1, 1, 1};

    do_reset();

    // Boundary table: one sample from empty, then TRIG seen one tick later.
    foreach (vt[i]) begin
      do_reset();
      tick(vt[i].adc, vt[i].thr, vt[i].ot, tr, cn);
      chk($sformatf("vec%0d_cnt", i), int'(cn), vt[i].exp_cnt);
      tick(12'd0, 12'd4095, vt[i].ot, tr, cn);
      chk($sformatf("vec%0d_trig", i), int'(tr), vt[i].exp_trig);
    end

    // Constant fill: +1 per tick to 120, TRIG first at tick 13 (after 13th sample).
    do_reset();
    first_trig = -1;
    for (int t = 0; t < 140; t++) begin
      tick(12'd100, 12'd50, 7'd13, tr, cn);
      if (tr && first_trig < 0) first_trig = t;
      if (t < WINDOW) chk("fill_ramp", int'(cn), t + 1);
    end
    chk("fill_first_trig", first_trig, 13);
    chk("fill_hold", int'(cn), 120);

    // Single pulse: count 1 for exactly WINDOW ticks, TRIG high for exactly WINDOW ticks.
    do_reset();
    trig_ticks = 0;
    for (int t = 0; t < 5; t++) tick(12'd0, 12'd50, 7'd1, tr, cn);
    tick(12'd60, 12'd50, 7'd1, tr, cn);
    chk("pulse_cnt", int'(cn), 1);
    for (int t = 1; t <= 130; t++) begin
      tick(12'd0, 12'd50, 7'd1, tr, cn);
      if (tr) trig_ticks++;
      if (t == WINDOW - 1) chk("pulse_last", int'(cn), 1);
      if (t == WINDOW)     chk("pulse_gone", int'(cn), 0);
    end
    chk("pulse_trig_len", trig_ticks, 120);

    // Equal values never count.
    do_reset();
    max_cnt = 0; any_trig = 0;
    for (int t = 0; t < 200; t++) begin
      tick(12'd50, 12'd50, 7'd1, tr, cn);
      if (int'(cn) > max_cnt) max_cnt = int'(cn);
      any_trig |= int'(tr);
    end
    chk("equal_max_cnt", max_cnt, 0);
    chk("equal_trig", any_trig, 0);

    // OCC_THRES = 0 disables; 121 is unreachable.
    do_reset();
    any_trig = 0;
    for (int t = 0; t < 125; t++) begin
      tick(12'd4000, 12'd10, 7'd0, tr, cn);
      any_trig |= int'(tr);
    end
    chk("ot0_cnt", int'(cn), 120);
    for (int t = 0; t < 5; t++) begin
      tick(12'd4000, 12'd10, 7'd121, tr, cn);
      any_trig |= int'(tr);
    end
    chk("ot0_121_trig", any_trig, 0);

    // Reset mid-window at phase 1 discards history.
    do_reset();
    for (int t = 0; t < 80; t++) tick(12'd100, 12'd50, 7'd13, tr, cn);
    chk("mid_fill", int'(cn), 80);
    @(negedge clk); ENABLE40 = 2'd0;
    @(posedge clk);
    @(negedge clk); ENABLE40 = 2'd1; RESET = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cnt", int'(OCC_COUNT), 0);
    chk("mid_rst_trig", int'(TRIG), 0);
    @(negedge clk); ENABLE40 = 2'd2; RESET = 1'b0;
    @(posedge clk);
    hist.delete();
    for (int t = 0; t < 130; t++) begin
      tick(12'd100, 12'd50, 7'd13, tr, cn);
      if (t == 0) chk("mid_restart", int'(cn), 1);
    end
    chk("mid_hold", int'(cn), 120);

    // Random stimulus with drifting threshold bias and occasional exact ties.
    do_reset();
    begin
      logic [11:0] a, th;
      logic [6:0]  ot;
      int lo = 0;
      ot = 7'd60;
      for (int t = 0; t < 10000; t++) begin
        if (t % 400 == 0) lo = $urandom_range(0, 3500);
        if (t % 97 == 0)  ot = 7'($urandom_range(0, 127));
        th = 12'($urandom_range(lo, 4095));
        a  = ($urandom_range(0, 15) == 0) ? th : 12'($urandom_range(0, 4095));
        tick(a, th, ot, tr, cn);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
